// File: rtl/ol_walker_pkg.sv
// rtl/ol_walker_pkg.sv - shared OPB decode constants and walker state encoding
// Purpose: object pointer block (OPB) field positions and type codes used by the
//          object-list walker, plus the walker state enum.
// Ports:   none (package pvr_ol_pkg)
package pvr_ol_pkg;

    // OPB type field, bits [31:29]. Strips are any code with bit 31 clear.
    localparam logic       OPB_STRIP      = 1'b0;
    localparam logic [2:0] OPB_TRI_ARRAY  = 3'b100;
    localparam logic [2:0] OPB_QUAD_ARRAY = 3'b101;
    localparam logic [2:0] OPB_RESERVED   = 3'b110;
    localparam logic [2:0] OPB_LINK       = 3'b111;

    // OPB bit positions
    localparam int OPB_TYPE_MSB  = 31;
    localparam int OPB_TYPE_LSB  = 29;
    localparam int OPB_EOL_BIT   = 28;
    localparam int OPB_PARAM_MSB = 20;
    localparam int OPB_LINK_MSB  = 23;
    localparam int OPB_LINK_LSB  = 2;

    // State codes kept as plain constants so legacy tools can decode dumps
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_ISSUE  = S_ISSUE,
        ST_WAIT   = S_WAIT,
        ST_DONE   = S_DONE
    } ol_state_e;

endpackage

// File: rtl/ol_walker_if.sv
// rtl/ol_walker_if.sv - VRAM read and primitive handshake bundle for the OL walker
// Purpose: groups the walker's VRAM read port and its render/drawn handshake with
//          the downstream ISP parameter parser.
// Ports:   master - walker side (drives rd/addr/opb_word/poly_addr/render_poly)
//          slave  - VRAM + parser side (drives din/ack/poly_drawn)
interface ol_walker_if #(
    parameter int ADDR_W = 24
);
    logic              ol_vram_rd;
    logic [ADDR_W-1:0] ol_vram_addr;
    logic [31:0]       ol_vram_din;
    logic              ol_vram_ack;
    logic [31:0]       opb_word;
    logic [ADDR_W-1:0] poly_addr;
    logic              render_poly;
    logic              poly_drawn;

    modport master (
        output ol_vram_rd, ol_vram_addr, opb_word, poly_addr, render_poly,
        input  ol_vram_din, ol_vram_ack, poly_drawn
    );

    modport slave (
        input  ol_vram_rd, ol_vram_addr, opb_word, poly_addr, render_poly,
        output ol_vram_din, ol_vram_ack, poly_drawn
    );
endinterface

// File: rtl/ol_walker.sv
// rtl/ol_walker.sv - PVR ISP object-list walker for one tile
// Purpose: walks a tile's object list in VRAM, follows block links, stops at
//          end-of-list, and hands each primitive OPB word and its parameter
//          address to the ISP parameter parser one at a time.
// Ports:   clock, reset_n       system clock, async active-low reset
//          start, ol_addr       begin walking at ol_addr (bits [1:0] ignored)
//          param_base           parameter buffer base byte address
//          bus (master)         VRAM rd/addr/din/ack, opb_word/poly_addr/render_poly/poly_drawn
//          busy, list_done      walk in progress / one-cycle completion pulse
//          list_err             sticky runaway-list abort flag
//          prim_count           primitives issued, saturating (only with OL_PRIM_COUNT_EN)
module ol_walker
    import pvr_ol_pkg::*;
#(
    parameter int MAX_ENTRIES = 1024,
    parameter int ADDR_W      = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] ol_addr,
    input  logic [ADDR_W-1:0] param_base,
    ol_walker_if.master       bus,
    output logic              busy,
    output logic              list_done,
    output logic              list_err
`ifdef OL_PRIM_COUNT_EN
    ,
    output logic [15:0]       prim_count
`endif
);

    localparam int                CNT_W     = $clog2(MAX_ENTRIES + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_ENTRIES);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    ol_state_e         r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_poly_addr;
    logic [CNT_W-1:0]  r_entry_cnt;
    logic [31:0]       r_opb;
    logic              r_rd;
    logic              r_render;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_drawn_seen;
`ifdef OL_PRIM_COUNT_EN
    logic [15:0]       r_prim_cnt;
`endif

    logic [2:0]        w_type;
    logic              w_eol;
    logic [ADDR_W-1:0] w_link_addr;
    logic [ADDR_W-1:0] w_poly_addr;
    logic [ADDR_W-1:0] w_start_addr;

    assign w_type       = r_opb[OPB_TYPE_MSB:OPB_TYPE_LSB];
    assign w_eol        = r_opb[OPB_EOL_BIT];
    assign w_link_addr  = ADDR_W'({r_opb[OPB_LINK_MSB:OPB_LINK_LSB], 2'b00});
    assign w_poly_addr  = param_base + ADDR_W'({r_opb[OPB_PARAM_MSB:0], 2'b00});
    assign w_start_addr = ol_addr & ~ADDR_W'(3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cur_addr   <= '0;
            r_poly_addr  <= '0;
            r_entry_cnt  <= '0;
            r_opb        <= '0;
            r_rd         <= 1'b0;
            r_render     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_drawn_seen <= 1'b0;
`ifdef OL_PRIM_COUNT_EN
            r_prim_cnt   <= '0;
`endif
        end else begin
            r_render <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur_addr  <= w_start_addr;
                        r_err       <= 1'b0;
                        r_entry_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_rd        <= 1'b1;
                        r_state     <= ST_FETCH;
`ifdef OL_PRIM_COUNT_EN
                        r_prim_cnt  <= '0;
`endif
                    end
                end
                ST_FETCH: begin
                    // rd and addr stay put until the ack is sampled
                    if (bus.ol_vram_ack) begin
                        r_opb       <= bus.ol_vram_din;
                        r_rd        <= 1'b0;
                        r_entry_cnt <= r_entry_cnt + 1'b1;
                        r_state     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // The runaway guard outranks whatever the word says,
                    // including an end-of-list link.
                    if (r_entry_cnt >= MAX_CNT) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_type == OPB_LINK) begin
                        if (w_eol) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cur_addr <= w_link_addr;
                            r_rd       <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end else if (w_type == OPB_RESERVED) begin
                        r_cur_addr <= r_cur_addr + WORD_STEP;
                        r_rd       <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else begin
                        // strip, triangle array or quad array
                        r_poly_addr  <= w_poly_addr;
                        r_render     <= 1'b1;
                        r_drawn_seen <= 1'b0;
                        r_cur_addr   <= r_cur_addr + WORD_STEP;
                        r_state      <= ST_ISSUE;
`ifdef OL_PRIM_COUNT_EN
                        if (r_prim_cnt != 16'hFFFF) begin
                            r_prim_cnt <= r_prim_cnt + 16'd1;
                        end
`endif
                    end
                end
                ST_ISSUE: begin
                    // A zero-latency parser may finish during the render pulse;
                    // remember it so WAIT leaves on its first cycle.
                    r_drawn_seen <= bus.poly_drawn;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.poly_drawn || r_drawn_seen) begin
                        r_drawn_seen <= 1'b0;
                        r_rd         <= 1'b1;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ol_vram_rd   = r_rd;
    assign bus.ol_vram_addr = r_cur_addr;
    assign bus.opb_word     = r_opb;
    assign bus.poly_addr    = r_poly_addr;
    assign bus.render_poly  = r_render;
    assign busy             = r_busy;
    assign list_done        = r_done;
    assign list_err         = r_err;
`ifdef OL_PRIM_COUNT_EN
    assign prim_count       = r_prim_cnt;
`endif

endmodule
